fp_mul_result_queue: RTL and testbench

FP_MUL_RESULT_QUEUE -- requirements
Module: fp_mul_result_queue

---
 rtl/fp_mul_result_queue_pkg.sv | 35 +++
 rtl/fp_mul_result_queue_classify.sv | 25 ++
 rtl/fp_mul_result_queue.sv | 135 +++++++++++++
 tb/tb_fp_mul_result_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_result_queue_pkg.sv
// Shared types for the FP multiplier result path: float classes, queue
// occupancy states and the bit positions of the {Z,N,O,U} flag nibble.
package fp_mul_result_queue_pkg;

  typedef enum logic [2:0] {
    FP_ZERO    = 3'd0,
    FP_SUBNORM = 3'd1,
    FP_NORMAL  = 3'd2,
    FP_INF     = 3'd3,
    FP_NAN     = 3'd4
  } fp_type_e;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  localparam int FLAG_U = 0;
  localparam int FLAG_O = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 3;

  // Classify a single-precision word; the sign bit never matters here.
  function automatic fp_type_e fp_type(input logic [31:0] w);
    fp_type_e t;
    if (w[30:0] == 31'd0)            t = FP_ZERO;
    else if (w[30:23] == 8'h00)      t = FP_SUBNORM;
    else if (w[30:23] != 8'hFF)      t = FP_NORMAL;
    else if (w[22:0] == 23'd0)       t = FP_INF;
    else                             t = FP_NAN;
    return t;
  endfunction

endpackage

// File: rtl/fp_mul_result_queue_classify.sv
// Combinational flag builder: turns a product word plus its upstream
// exception flags into the {Z,N,O,U} nibble stored alongside the word.
module fp_flag_classify
  import fp_mul_result_queue_pkg::*;
(
  input  logic [31:0] result,
  input  logic        u,
  input  logic        o,
  input  logic        n,
  output logic [3:0]  flags
);

  fp_type_e cls;

  // A NaN encoding is reported as N even if upstream did not flag it.
  always_comb begin
    cls           = fp_type(result);
    flags         = 4'b0000;
    flags[FLAG_U] = u;
    flags[FLAG_O] = o;
    flags[FLAG_N] = n | (cls == FP_NAN);
    flags[FLAG_Z] = (cls == FP_ZERO);
  end

endmodule

// File: rtl/fp_mul_result_queue.sv
// Result queue for the FP multiplier. Holds DEPTH product words with their
// classified flags and accumulates sticky exception bits and counters.
// Handshake: a transfer happens on a rising edge where valid && ready;
// in_ready and out_valid depend only on registered occupancy, never on
// the same-cycle inputs, and the head payload is held until popped.
module fp_mul_result_queue
  import fp_mul_result_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_result,
  input  logic                     in_u,
  input  logic                     in_o,
  input  logic                     in_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level,
  input  logic                     clr_stat,
  output logic                     sticky_u,
  output logic                     sticky_o,
  output logic                     sticky_n,
  output logic [CNT_W-1:0]         uf_cnt,
  output logic [CNT_W-1:0]         of_cnt,
  output logic [CNT_W-1:0]         nan_cnt,
  output occ_e                     occ_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [31:0]      res_mem  [DEPTH];
  logic [3:0]       flag_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  occ_e             state;
  occ_e             state_nxt;
  logic             push;
  logic             pop;
  logic [3:0]       in_flags;
  logic [2:0]       sticky;
  logic [CNT_W-1:0] cnt [3];

  fp_flag_classify u_classify (
    .result (in_result),
    .u      (in_u),
    .o      (in_o),
    .n      (in_n),
    .flags  (in_flags)
  );

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= OCC_EMPTY;
    else        state <= state_nxt;
  end

  // Occupancy next state; simultaneous push and pop leave it unchanged.
  always_comb begin
    state_nxt = state;
    if (push && !pop)
      state_nxt = (level_q == LVL_W'(DEPTH - 1)) ? OCC_FULL : OCC_PARTIAL;
    else if (pop && !push)
      state_nxt = (level_q == LVL_W'(1)) ? OCC_EMPTY : OCC_PARTIAL;
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state != OCC_FULL);
    out_valid = (state != OCC_EMPTY);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
    end
  end

  // Storage array is deliberately not reset; the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[wr_ptr]  <= in_result;
      flag_mem[wr_ptr] <= in_flags;
    end
  end

  // Sticky bits and saturating counters; a flagged push beats clr_stat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push && in_flags[i]) begin
          sticky[i] <= 1'b1;
          if (clr_stat)     cnt[i] <= CNT_W'(1);
          else if (!(&cnt[i])) cnt[i] <= cnt[i] + CNT_W'(1);
        end else if (clr_stat) begin
          sticky[i] <= 1'b0;
          cnt[i]    <= '0;
        end
      end
    end
  end

  assign out_result = out_valid ? res_mem[rd_ptr]  : 32'd0;
  assign out_flags  = out_valid ? flag_mem[rd_ptr] : 4'd0;
  assign level      = level_q;
  assign occ_state  = state;
  assign sticky_u   = sticky[FLAG_U];
  assign sticky_o   = sticky[FLAG_O];
  assign sticky_n   = sticky[FLAG_N];
  assign uf_cnt     = cnt[FLAG_U];
  assign of_cnt     = cnt[FLAG_O];
  assign nan_cnt    = cnt[FLAG_N];

endmodule

// File: tb/tb_fp_mul_result_queue.sv
// Directed bench for fp_mul_result_queue (DEPTH=4, CNT_W=8).
module tb_fp_mul_result_queue;
  import fp_mul_result_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_result;
  logic              in_u;
  logic              in_o;
  logic              in_n;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;
  logic [2:0]        level;
  logic              clr_stat;
  logic              sticky_u;
  logic              sticky_o;
  logic              sticky_n;
  logic [CNT_W-1:0]  uf_cnt;
  logic [CNT_W-1:0]  of_cnt;
  logic [CNT_W-1:0]  nan_cnt;
  occ_e              occ_state;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_u       (in_u),
    .in_o       (in_o),
    .in_n       (in_n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .level      (level),
    .clr_stat   (clr_stat),
    .sticky_u   (sticky_u),
    .sticky_o   (sticky_o),
    .sticky_n   (sticky_n),
    .uf_cnt     (uf_cnt),
    .of_cnt     (of_cnt),
    .nan_cnt    (nan_cnt),
    .occ_state  (occ_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, score any push/pop, advance to edge+1.
  task automatic cycle(input logic v, input logic [31:0] d, input logic u,
                       input logic o, input logic n, input logic rdy,
                       input logic clr);
    in_valid  = v;
    in_result = d;
    in_u      = u;
    in_o      = o;
    in_n      = n;
    out_ready = rdy;
    clr_stat  = clr;
    #1;
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
      else                   check("pop_order", out_result, exp_q.pop_front());
    end
    if (v && in_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_stat = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  logic [31:0] words [5];

  initial begin
    words[0] = 32'h3F800000; words[1] = 32'h40000000; words[2] = 32'h40400000;
    words[3] = 32'h40800000; words[4] = 32'h40A00000;
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_u = 1'b0; in_o = 1'b0;
    in_n = 1'b0; out_ready = 1'b0; clr_stat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",     32'(level), 32'd0);
    check("rst_in_ready",  32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_sticky", {29'd0, sticky_n, sticky_o, sticky_u}, 32'd0);
    check("rst_counters", {8'd0, uf_cnt, of_cnt, nan_cnt}, 32'd0);
    check("rst_state", 32'(occ_state), 32'(OCC_EMPTY));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First push: not visible in its own cycle, visible the next.
    in_valid = 1'b1; in_result = 32'h3F800000; #1;
    check("no_fallthrough", 32'(out_valid), 32'd0);
    push(32'h3F800000);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_result", out_result, 32'h3F800000);
    check("first_flags", 32'(out_flags), 32'h0);
    check("first_level", 32'(level), 32'd1);
    check("first_state", 32'(occ_state), 32'(OCC_PARTIAL));
    drain(1);
    check("drain1_level", 32'(level), 32'd0);

    // Fill to four, fifth word dropped while full.
    for (int i = 0; i < 4; i++) push(words[i]);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(level), 32'd4);
    check("full_state", 32'(occ_state), 32'(OCC_FULL));
    push(words[4]);
    check("drop_level", 32'(level), 32'd4);
    check("hold_head", out_result, 32'h3F800000);
    // Full with both valid and ready: pop only.
    cycle(1'b1, 32'h40C00000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop_level", 32'(level), 32'd3);
    push(32'h40C00000);
    check("refill_level", 32'(level), 32'd4);
    check("refill_head", out_result, 32'h40000000);
    drain(4);
    check("drain_level", 32'(level), 32'd0);
    check("drain_empty_q", 32'(exp_q.size()), 32'd0);
    // Pop request while empty is ignored.
    drain(1);
    check("empty_pop_level", 32'(level), 32'd0);

    // Level 2 with simultaneous push and pop across pointer wrap.
    push(32'h41000000);
    push(32'h41100000);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 32'h41200000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("pp_level", 32'(level), 32'd2);
    end
    check("pp_head", out_result, 32'h41200001);
    drain(2);

    // Quiet NaN with in_n low is still classified N.
    push(32'h7FC00000);
    check("nan_flags", 32'(out_flags), 32'b0100);
    check("nan_sticky", 32'(sticky_n), 32'd1);
    check("nan_cnt", 32'(nan_cnt), 32'd1);
    drain(1);
    push(32'h00000000);
    check("zero_flags", 32'(out_flags), 32'b1000);
    drain(1);
    push(32'h80000000);
    check("negzero_flags", 32'(out_flags), 32'b1000);
    drain(1);
    push(32'h7F800000);
    check("inf_flags", 32'(out_flags), 32'b0000);
    drain(1);
    cycle(1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("uf_flags", 32'(out_flags), 32'b0001);
    check("uf_cnt", 32'(uf_cnt), 32'd1);
    check("sticky_u", 32'(sticky_u), 32'd1);

    // clr_stat with an entry queued: stats cleared, queue untouched.
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_level", 32'(level), 32'd1);
    check("clr_head", out_result, 32'h00000001);
    check("clr_counts", {8'd0, uf_cnt, of_cnt, nan_cnt}, 32'd0);
    check("clr_sticky", {29'd0, sticky_n, sticky_o, sticky_u}, 32'd0);
    drain(1);

    // Overflow counter: 254 then saturate after 2^8+3 pushes.
    for (int i = 0; i < 254; i++)
      cycle(1'b1, 32'h3F800000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("of_cnt_254", 32'(of_cnt), 32'd254);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 32'h40000000 + 32'(i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("of_cnt_sat", 32'(of_cnt), 32'hFF);
    check("sticky_o_sat", 32'(sticky_o), 32'd1);
    // Push wins over a simultaneous clear.
    cycle(1'b1, 32'h42000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("clr_push_of_cnt", 32'(of_cnt), 32'd1);
    check("clr_push_sticky_o", 32'(sticky_o), 32'd1);
    check("clr_push_uf_cnt", 32'(uf_cnt), 32'd0);
    drain(1);
    check("burst_end_level", 32'(level), 32'd0);

    // Asynchronous reset mid-burst discards the entries at once.
    push(32'h43000000);
    push(32'h43100000);
    push(32'h43200000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_result", out_result, 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain(2);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    push(32'h44000000);
    check("post_rst_head", out_result, 32'h44000000);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
